// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wb_arbiter                                                       |
// | Brief   : Regfile write-port arbiter. The pipeline write always wins, and  |
// |           long-latency writes queue in a FIFO that drains in idle cycles.  |
// | Option  : WB_PENDING_CHECK_EN adds pending-write address compare ports.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_we,
  input  logic [ADDR_W-1:0]          pipe_waddr,
  input  logic [DATA_W-1:0]          pipe_wdata,
  input  logic                       ll_valid,
  output logic                       ll_ready,
  input  logic [ADDR_W-1:0]          ll_waddr,
  input  logic [DATA_W-1:0]          ll_wdata,
`ifdef WB_PENDING_CHECK_EN
  input  logic [ADDR_W-1:0]          chk_addr1,
  input  logic [ADDR_W-1:0]          chk_addr2,
  output logic                       chk_hit1,
  output logic                       chk_hit2,
`endif
  output logic                       we,
  output logic [ADDR_W-1:0]          waddr,
  output logic [DATA_W-1:0]          wdata,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       stallreq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);
  localparam logic [CW-1:0] c_depth      = CW'(DEPTH);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;
  logic              r_stall;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic w_pipe_valid;
  logic w_empty;
  logic w_pop;
  logic w_accept;
  logic w_push;

  // Writes to r0 are no-ops: they neither claim the port nor occupy a FIFO slot.
  assign w_pipe_valid = pipe_we & (pipe_waddr != '0);
  assign w_empty      = (r_count == '0);
  assign w_pop        = ~w_pipe_valid & ~w_empty;
  // Readiness looks only at the registered count, so a pop never feeds back into ll_ready.
  assign ll_ready     = (r_count < c_depth) & ~rst;
  assign w_accept     = ll_valid & ll_ready;
  assign w_push       = w_accept & (ll_waddr != '0);

  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign fifo_count = r_count;
  assign stallreq   = r_stall;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr] <= ll_waddr;
      r_mem_data[r_wr] <= ll_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_pipe_valid) begin
        r_we    <= 1'b1;
        r_waddr <= pipe_waddr;
        r_wdata <= pipe_wdata;
      end else if (w_pop) begin
        r_we    <= 1'b1;
        r_waddr <= r_mem_addr[r_rd];
        r_wdata <= r_mem_data[r_rd];
      end else begin
        r_we <= 1'b0;
      end

      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);

      if (w_push & ~w_pop)
        r_count <= r_count + CW'(1);
      else if (~w_push & w_pop)
        r_count <= r_count - CW'(1);

      // Non-empty without a pop means the pipeline took the port this cycle.
      if (w_pop | w_empty) begin
        r_starve <= '0;
        r_stall  <= 1'b0;
      end else begin
        if (r_starve != c_starve_max) r_starve <= r_starve + SW'(1);
        if (r_starve == c_starve_max) r_stall  <= 1'b1;
      end
    end
  end

`ifdef WB_PENDING_CHECK_EN
  logic [DEPTH-1:0] w_ent_valid;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [PW-1:0] w_off;
      assign w_off           = PW'(gi) - r_rd;
      assign w_ent_valid[gi] = (CW'(w_off) < r_count);
    end
  endgenerate

  always_comb begin
    chk_hit1 = w_accept & (ll_waddr == chk_addr1);
    chk_hit2 = w_accept & (ll_waddr == chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (r_mem_addr[i] == chk_addr1)) chk_hit1 = 1'b1;
      if (w_ent_valid[i] && (r_mem_addr[i] == chk_addr2)) chk_hit2 = 1'b1;
    end
    if (chk_addr1 == '0) chk_hit1 = 1'b0;
    if (chk_addr2 == '0) chk_hit2 = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_wb_arbiter                                                    |
// | Brief   : Directed vector table, starvation sequence and randomized run    |
// |           against a queue-based reference model of the write arbiter.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_waddr;
  logic [31:0] ll_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  fifo_count;
  logic        stallreq;

  int n_checks = 0;
  int n_err    = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        m_q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_lost;
  logic        m_stall;

  task automatic model_update(input logic r, input logic pw, input logic [4:0] pa,
                              input logic [31:0] pd, input logic lv,
                              input logic [4:0] la, input logic [31:0] ld);
    bit   pv, acc;
    ent_t e;
    if (r) begin
      m_q.delete();
      m_we = 0; m_wa = 0; m_wd = 0; m_lost = 0; m_stall = 0;
      return;
    end
    pv  = pw && (pa != 0);
    acc = lv && (m_q.size() < DEPTH);
    if (pv) begin
      m_we = 1; m_wa = pa; m_wd = pd;
      if (m_q.size() > 0) begin
        m_stall = (m_lost >= STARVE_MAX);
        m_lost  = (m_lost >= STARVE_MAX) ? STARVE_MAX : m_lost + 1;
      end else begin
        m_lost = 0; m_stall = 0;
      end
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1; m_wa = e.a; m_wd = e.d;
      m_lost = 0; m_stall = 0;
    end else begin
      m_we = 0; m_lost = 0; m_stall = 0;
    end
    if (acc && la != 0) begin
      e.a = la; e.d = ld;
      m_q.push_back(e);
    end
  endtask

  // Drive one cycle, check ll_ready before the edge and all registered outputs after it.
  task automatic step(input logic r, input logic pw, input logic [4:0] pa,
                      input logic [31:0] pd, input logic lv,
                      input logic [4:0] la, input logic [31:0] ld);
    rst = r; pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    ll_valid = lv; ll_waddr = la; ll_wdata = ld;
    #1;
    chk("model ll_ready", 32'(ll_ready), 32'(!r && m_q.size() < DEPTH));
    model_update(r, pw, pa, pd, lv, la, ld);
    @(posedge clk); #1;
    chk("model we",         32'(we),         32'(m_we));
    chk("model waddr",      32'(waddr),      32'(m_wa));
    chk("model wdata",      wdata,           m_wd);
    chk("model fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("model stallreq",   32'(stallreq),   32'(m_stall));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_rdy, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_stall;
  } vec_t;

  vec_t vecs[14];
  int   pct;

  initial begin
    rst = 1; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    ll_valid = 0; ll_waddr = 0; ll_wdata = 0;

    //            rst pw pa  pd        lv la  ld      rdy we wa  wd        cnt st
    vecs[0]  = '{1'b1, 0, 0, 32'h0,    0, 0, 32'h0,  0, 0, 0, 32'h0,    0, 0};
    vecs[1]  = '{1'b0, 1, 5, 32'h1234, 0, 0, 32'h0,  1, 1, 5, 32'h1234, 0, 0};
    vecs[2]  = '{1'b0, 0, 0, 32'h0,    1, 7, 32'hAA, 1, 0, 5, 32'h1234, 1, 0};
    vecs[3]  = '{1'b0, 0, 0, 32'h0,    0, 0, 32'h0,  1, 1, 7, 32'hAA,   0, 0};
    vecs[4]  = '{1'b0, 1, 0, 32'hDEAD, 1, 3, 32'h33, 1, 0, 7, 32'hAA,   1, 0};
    vecs[5]  = '{1'b0, 1, 9, 32'h99,   1, 4, 32'h44, 1, 1, 9, 32'h99,   2, 0};
    vecs[6]  = '{1'b0, 0, 0, 32'h0,    1, 6, 32'h66, 1, 1, 3, 32'h33,   2, 0};
    vecs[7]  = '{1'b0, 1, 0, 32'h0,    1, 0, 32'h55, 1, 1, 4, 32'h44,   1, 0};
    vecs[8]  = '{1'b0, 0, 0, 32'h0,    0, 0, 32'h0,  1, 1, 6, 32'h66,   0, 0};
    vecs[9]  = '{1'b0, 1, 2, 32'h22,   1, 1, 32'h11, 1, 1, 2, 32'h22,   1, 0};
    vecs[10] = '{1'b0, 1, 2, 32'h23,   1, 2, 32'h12, 1, 1, 2, 32'h23,   2, 0};
    vecs[11] = '{1'b0, 1, 2, 32'h24,   1, 3, 32'h13, 1, 1, 2, 32'h24,   3, 0};
    vecs[12] = '{1'b1, 0, 0, 32'h0,    1, 4, 32'h14, 0, 0, 0, 32'h0,    0, 0};
    vecs[13] = '{1'b0, 0, 0, 32'h0,    0, 0, 32'h0,  1, 0, 0, 32'h0,    0, 0};

    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; pipe_we = vecs[i].pw; pipe_waddr = vecs[i].pa;
      pipe_wdata = vecs[i].pd; ll_valid = vecs[i].lv; ll_waddr = vecs[i].la;
      ll_wdata = vecs[i].ld;
      #1;
      chk($sformatf("vec%0d ll_ready", i), 32'(ll_ready), 32'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d we", i),         32'(we),         32'(vecs[i].e_we));
      chk($sformatf("vec%0d waddr", i),      32'(waddr),      32'(vecs[i].e_wa));
      chk($sformatf("vec%0d wdata", i),      wdata,           vecs[i].e_wd);
      chk($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d stallreq", i),   32'(stallreq),   32'(vecs[i].e_stall));
    end

    // Starvation: pipe writes every cycle while four LL writes fill the FIFO.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 32'(100 + i), 1, 5'(10 + i), 32'(200 + i));
    #1;
    chk("starve ll_ready full", 32'(ll_ready), 32'(0));
    chk("starve count full",    32'(fifo_count), 32'(4));
    for (int j = 0; j < 6; j++) begin
      step(0, 1, 1, 32'(300 + j), 1, 20, 32'h77);
      chk($sformatf("starve stallreq %0d", j), 32'(stallreq), 32'(j == 5));
    end
    step(0, 0, 0, 0, 1, 20, 32'h77);
    chk("starve release stallreq", 32'(stallreq), 32'(0));
    chk("starve release waddr",    32'(waddr),    32'(10));
    chk("starve release wdata",    wdata,         32'(200));

    // Randomized traffic against the reference model.
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      logic       r, pw, lv;
      logic [4:0] pa, la;
      if (c % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 10;
          1: pct = 50;
          2: pct = 90;
          default: pct = 100;
        endcase
      end
      r  = ($urandom_range(0, 299) == 0);
      pw = ($urandom_range(0, 99) < pct);
      pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lv = ($urandom_range(0, 1) == 1);
      la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(r, pw, pa, $urandom, lv, la, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
